atmega_tim4: RTL
================

Name: atmega_tim4

Overview:
- ATmega32U4-style Timer/Counter4: 10-bit high-speed timer with prescaler, TOP register OCR4C, two compare channels A/B with simple PWM outputs, and overflow/compare interrupts.
- Sits directly downstream of the PLL block: consumes its tim_ck_o and pll_enabled_o as a count-enable source.
- Register access uses the same data-space bus as the other peripherals.

Parameters:
- BUS_ADDR_DATA_LEN, 16, width of addr_i.
- TCNT4_ADDR, 'hBE, counter low byte.
- TC4H_ADDR, 'hBF, shared 10-bit high-byte temp register.
- TCCR4A_ADDR, 'hC0, control A.
- TCCR4B_ADDR, 'hC1, control B.
- OCR4A_ADDR, 'hCF, compare A low byte.
- OCR4B_ADDR, 'hD0, compare B low byte.
- OCR4C_ADDR, 'hD1, TOP low byte.
- TIMSK4_ADDR, 'h72, interrupt mask.
- TIFR4_ADDR, 'h39, interrupt flags.

Ports:
- clk_i  in  1  core clock; all state on posedge.
- rst_ni  in  1  asynchronous active-low reset.
- addr_i  in  BUS_ADDR_DATA_LEN  register address.
- wr_i  in  1  write strobe, one cycle.
- rd_i  in  1  read strobe, one cycle.
- bus_i  in  8  write data.
- bus_o  out  8  read data; 0 when not selected.
- tim_ck_i  in  1  timer clock from PLL block.
- pll_enabled_i  in  1  1 = count on tim_ck_i rising edges; 0 = count enable every clk_i cycle.
- ovf_ack_i, compa_ack_i, compb_ack_i  in  1 each  interrupt acknowledge; clears the matching flag.
- irq_ovf_o, irq_compa_o, irq_compb_o  out  1 each  flag AND mask (combinational).
- oc4a_o, oc4b_o  out  1 each  PWM outputs.

Behaviour:
- Reset (async, rst_ni=0):
  - All registers 0 except OCR4C=10'h0FF.
  - Prescaler, sync flops and oc4a_o/oc4b_o = 0; all irq outputs 0.
- Count enable (ce):
  - pll_enabled_i=0: ce=1 every cycle.
  - pll_enabled_i=1: tim_ck_i passes through a 2-flop synchroniser plus edge-detect flop; ce is a one-cycle pulse per rising edge, 3 cycles after the edge.
  - Edges closer than 2 clk_i cycles apart may be lost; this is accepted.
- Prescaler:
  - CS=TCCR4B[3:0]. CS=0 stops the timer: no ticks, prescaler holds.
  - CS=n in 1..15 divides by 2^(n-1) using a 14-bit counter incremented on ce.
  - tick = ce AND (low n-1 counter bits all 1); for n=1, tick=ce.
  - Writing 1 to TCCR4B[6] (PSR4) clears the prescaler counter that cycle. PSR4 is not stored and reads 0.
- 10-bit access via TC4H, whose bits [1:0] are stored:
  - Writing TCNT4/OCR4x loads {TC4H[1:0], bus_i}.
  - Reading TCNT4 returns TCNT[7:0] and, same cycle, latches TCNT[9:8] into TC4H.
  - Reading OCR4x returns the low byte and latches its high bits into TC4H.
  - TC4H reads {6'b0, TC4H[1:0]}.
- Counter (on tick):
  - If TCNT==OCR4C: TCNT<=0 and TOV4 set.
  - Else TCNT<=TCNT+1.
  - OCR4C=0 gives TCNT held 0 with TOV4 set on every tick.
  - If TCNT>OCR4C (after a software write), counting continues to 10'h3FF, then wraps to 0 without setting TOV4.
- Compare:
  - On tick, if TCNT (pre-increment value) == OCR4A, OCF4A is set; same rule for B.
  - A bus write to TCNT4 suppresses compare matches on the next tick only.
- Flags, TIFR4 bits:
  - OCF4A=[6], OCF4B=[5], TOV4=[2]; other bits read 0.
  - Writing 1 to a bit clears it.
  - Ack inputs clear the matching flag.
  - A hardware set in the same cycle as a clear (write or ack) wins: flag stays 1.
- TIMSK4 uses the same bit positions; other bits read 0.
- PWM, TCCR4A[0]=PWM4A, TCCR4A[1]=PWM4B:
  - If enabled: oc4x_o set to 1 on the tick where TCNT wraps to 0; cleared on the tick of compare match x.
  - If OCR4x > OCR4C, the output stays 1 after the first wrap.
  - Match and wrap on the same tick (OCR4x==OCR4C): clear wins, so output is constant 0.
  - If disabled: oc4x_o=0.
- Registers are written on the cycle wr_i is sampled.
- Bus write and hardware update of TCNT in the same cycle: write wins, and no tick is applied.
- bus_o is combinational: 0 unless rd_i=1, rst_ni=1 and the address matches.

Test Plan:
- Reset, then read all registers -> OCR4C reads 8'hFF with TC4H then 0; all others read 0; irq and oc outputs 0.
- pll_enabled_i=0, CS=1, OCR4C=5, TIMSK4=8'h04 -> TCNT sequence 0,1,2,3,4,5,0; TOV4 and irq_ovf_o rise the cycle after the 5->0 tick; ovf_ack_i clears it.
- CS=4 (div 8), pll_enabled_i=0 -> TCNT increments once per 8 clk_i; PSR4 write mid-count delays the next tick to 8 cycles after the write.
- TC4H=2, write TCNT4=8'h10 -> TCNT=10'h210; read TCNT4 returns 8'h10 and TC4H reads 8'h02; the next tick at TCNT==OCR4A gives no OCF4A.
- PWM4A=1, OCR4C=9, OCR4A=3, CS=1 -> oc4a_o high 4 ticks, low 6 ticks, period 10; OCR4A=9 -> oc4a_o constant 0.
- pll_enabled_i=1, tim_ck_i toggling every 4 clk_i, CS=1 -> one increment per tim_ck_i period; first increment 3 cycles after the rising edge; TIFR4 write-1 coinciding with a new match leaves the flag set.

Source files
------------

// File: rtl/atmega_tim4.sv
// ATmega32U4-style Timer/Counter4: 10-bit timer with prescaler, OCR4C as TOP,
// two compare/PWM channels and overflow/compare interrupt flags.
module atmega_tim4 #(
  parameter int                           BUS_ADDR_DATA_LEN = 16,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCNT4_ADDR        = 'hBE,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TC4H_ADDR         = 'hBF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCCR4A_ADDR       = 'hC0,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCCR4B_ADDR       = 'hC1,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] OCR4A_ADDR        = 'hCF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] OCR4B_ADDR        = 'hD0,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] OCR4C_ADDR        = 'hD1,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIMSK4_ADDR       = 'h72,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIFR4_ADDR        = 'h39
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  input  logic                         tim_ck_i,
  input  logic                         pll_enabled_i,
  input  logic                         ovf_ack_i,
  input  logic                         compa_ack_i,
  input  logic                         compb_ack_i,
  output logic                         irq_ovf_o,
  output logic                         irq_compa_o,
  output logic                         irq_compb_o,
  output logic                         oc4a_o,
  output logic                         oc4b_o
);

  logic [9:0]  tcnt_reg, ocr4a_reg, ocr4b_reg, ocr4c_reg;
  logic [1:0]  tc4h_reg;
  logic [7:0]  tccr4a_reg, tccr4b_reg;
  logic [2:0]  timsk_reg, tifr_reg;  // bit order {OCF4A, OCF4B, TOV4}
  logic [13:0] psc_reg;
  logic        sync1_reg, sync2_reg, sync3_reg;
  logic        sup_reg, oc4a_reg, oc4b_reg;

  logic wr_tcnt, wr_tc4h, wr_tccra, wr_tccrb, wr_ocra, wr_ocrb, wr_ocrc, wr_timsk, wr_tifr;
  logic rd_tcnt, rd_ocra, rd_ocrb, rd_ocrc;

  assign wr_tcnt  = wr_i & (addr_i == TCNT4_ADDR);
  assign wr_tc4h  = wr_i & (addr_i == TC4H_ADDR);
  assign wr_tccra = wr_i & (addr_i == TCCR4A_ADDR);
  assign wr_tccrb = wr_i & (addr_i == TCCR4B_ADDR);
  assign wr_ocra  = wr_i & (addr_i == OCR4A_ADDR);
  assign wr_ocrb  = wr_i & (addr_i == OCR4B_ADDR);
  assign wr_ocrc  = wr_i & (addr_i == OCR4C_ADDR);
  assign wr_timsk = wr_i & (addr_i == TIMSK4_ADDR);
  assign wr_tifr  = wr_i & (addr_i == TIFR4_ADDR);
  assign rd_tcnt  = rd_i & (addr_i == TCNT4_ADDR);
  assign rd_ocra  = rd_i & (addr_i == OCR4A_ADDR);
  assign rd_ocrb  = rd_i & (addr_i == OCR4B_ADDR);
  assign rd_ocrc  = rd_i & (addr_i == OCR4C_ADDR);

  logic [3:0]  cs;
  logic [13:0] psc_mask;
  logic        ce, run, tick, at_top, wrap, match_a, match_b;
  logic [2:0]  set_flags, clr_flags;

  assign cs  = tccr4b_reg[3:0];
  assign ce  = pll_enabled_i ? (sync2_reg & ~sync3_reg) : 1'b1;
  assign run = ce & (cs != 4'd0);

  always_comb begin
    psc_mask = '0;
    if (cs != 4'd0) psc_mask = (14'd1 << (cs - 4'd1)) - 14'd1;
  end

  // A TCNT write in the same cycle takes priority, so that tick is dropped.
  assign tick    = run & ((psc_reg & psc_mask) == psc_mask) & ~wr_tcnt;
  assign at_top  = (tcnt_reg == ocr4c_reg);
  assign wrap    = tick & (at_top | (tcnt_reg == 10'h3FF));
  assign match_a = tick & ~sup_reg & (tcnt_reg == ocr4a_reg);
  assign match_b = tick & ~sup_reg & (tcnt_reg == ocr4b_reg);

  assign set_flags = {match_a, match_b, tick & at_top};
  assign clr_flags = ({3{wr_tifr}} & {bus_i[6], bus_i[5], bus_i[2]})
                   | {compa_ack_i, compb_ack_i, ovf_ack_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_reg   <= '0;
      ocr4a_reg  <= '0;
      ocr4b_reg  <= '0;
      ocr4c_reg  <= 10'h0FF;
      tc4h_reg   <= '0;
      tccr4a_reg <= '0;
      tccr4b_reg <= '0;
      timsk_reg  <= '0;
      tifr_reg   <= '0;
      psc_reg    <= '0;
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      sync3_reg  <= 1'b0;
      sup_reg    <= 1'b0;
      oc4a_reg   <= 1'b0;
      oc4b_reg   <= 1'b0;
    end else begin
      sync1_reg <= tim_ck_i;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;

      if (wr_tccrb && bus_i[6]) psc_reg <= '0;
      else if (run)             psc_reg <= psc_reg + 14'd1;

      if (wr_tcnt) begin
        tcnt_reg <= {tc4h_reg, bus_i};
        sup_reg  <= 1'b1;
      end else if (tick) begin
        tcnt_reg <= at_top ? 10'd0 : tcnt_reg + 10'd1;
        sup_reg  <= 1'b0;
      end

      // Hardware set wins over a simultaneous software/ack clear.
      tifr_reg <= (tifr_reg & ~clr_flags) | set_flags;

      if (!tccr4a_reg[0])  oc4a_reg <= 1'b0;
      else if (match_a)    oc4a_reg <= 1'b0;
      else if (wrap)       oc4a_reg <= 1'b1;

      if (!tccr4a_reg[1])  oc4b_reg <= 1'b0;
      else if (match_b)    oc4b_reg <= 1'b0;
      else if (wrap)       oc4b_reg <= 1'b1;

      if (wr_tc4h)      tc4h_reg <= bus_i[1:0];
      else if (rd_tcnt) tc4h_reg <= tcnt_reg[9:8];
      else if (rd_ocra) tc4h_reg <= ocr4a_reg[9:8];
      else if (rd_ocrb) tc4h_reg <= ocr4b_reg[9:8];
      else if (rd_ocrc) tc4h_reg <= ocr4c_reg[9:8];

      if (wr_tccra) tccr4a_reg <= bus_i;
      if (wr_tccrb) tccr4b_reg <= bus_i & 8'hBF;
      if (wr_ocra)  ocr4a_reg  <= {tc4h_reg, bus_i};
      if (wr_ocrb)  ocr4b_reg  <= {tc4h_reg, bus_i};
      if (wr_ocrc)  ocr4c_reg  <= {tc4h_reg, bus_i};
      if (wr_timsk) timsk_reg  <= {bus_i[6], bus_i[5], bus_i[2]};
    end
  end

  always_comb begin
    bus_o = 8'h00;
    if (rd_i && rst_ni) begin
      case (addr_i)
        TCNT4_ADDR:  bus_o = tcnt_reg[7:0];
        TC4H_ADDR:   bus_o = {6'b0, tc4h_reg};
        TCCR4A_ADDR: bus_o = tccr4a_reg;
        TCCR4B_ADDR: bus_o = tccr4b_reg;
        OCR4A_ADDR:  bus_o = ocr4a_reg[7:0];
        OCR4B_ADDR:  bus_o = ocr4b_reg[7:0];
        OCR4C_ADDR:  bus_o = ocr4c_reg[7:0];
        TIMSK4_ADDR: bus_o = {1'b0, timsk_reg[2:1], 2'b0, timsk_reg[0], 2'b0};
        TIFR4_ADDR:  bus_o = {1'b0, tifr_reg[2:1], 2'b0, tifr_reg[0], 2'b0};
        default:     bus_o = 8'h00;
      endcase
    end
  end

  assign irq_ovf_o   = tifr_reg[0] & timsk_reg[0];
  assign irq_compb_o = tifr_reg[1] & timsk_reg[1];
  assign irq_compa_o = tifr_reg[2] & timsk_reg[2];
  assign oc4a_o      = oc4a_reg;
  assign oc4b_o      = oc4b_reg;

endmodule
